// File: rtl/fir_filter_core.sv
// fir_filter_core: fixed-coefficient direct-form FIR for signed Q1.(DW-1) samples.
// Three enabled stages: tap shift, saturated scaled products, saturated sum.
// Every register advances only on edges with i_en=1.
module fir_filter_core #(
    parameter int DATA_WIDTH = 24,
    parameter int FIR_DEPTH  = 8,
    parameter logic [FIR_DEPTH*DATA_WIDTH-1:0] COEFFS =
        {FIR_DEPTH{DATA_WIDTH'((1 << (DATA_WIDTH - 1)) / FIR_DEPTH)}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] iv_din,
    output logic [DATA_WIDTH-1:0] ov_dout,
    output logic                  o_prod_overflow,
    output logic                  o_sum_overflow
);

    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH + $clog2(FIR_DEPTH);

    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0]        tap      [FIR_DEPTH];
    logic [DW-1:0]        prod     [FIR_DEPTH];
    logic [DW-1:0]        prod_nxt [FIR_DEPTH];
    logic [FIR_DEPTH-1:0] pov;
    logic [FIR_DEPTH-1:0] pov_nxt;
    logic [2*DW-1:0]      full;
    logic [2*DW-1:0]      shr;
    logic [DW-1:0]        coef;
    logic [SW-1:0]        sum;
    logic [DW-1:0]        dout_nxt;
    logic                 sov_nxt;

    // Scaled products: full-width signed multiply, floor shift, clamp to DW range.
    always_comb begin
        full    = '0;
        shr     = '0;
        coef    = '0;
        pov_nxt = '0;
        for (int unsigned k = 0; k < FIR_DEPTH; k++) begin
            prod_nxt[k] = '0;
        end
        for (int unsigned k = 0; k < FIR_DEPTH; k++) begin
            coef = COEFFS[k*DW +: DW];
            full = $signed({{DW{tap[k][DW-1]}}, tap[k]}) * $signed({{DW{coef[DW-1]}}, coef});
            shr  = $signed(full) >>> (DW - 1);
            // The value fits in DW bits only when the top DW+1 bits are all equal.
            if ((&shr[2*DW-1:DW-1]) || !(|shr[2*DW-1:DW-1])) begin
                prod_nxt[k] = shr[DW-1:0];
            end else begin
                prod_nxt[k] = shr[2*DW-1] ? NEG_MIN : POS_MAX;
                pov_nxt[k]  = 1'b1;
            end
        end
    end

    // Adder tree in DW+clog2(DEPTH) bits, then clamp back to the sample range.
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < FIR_DEPTH; k++) begin
            sum = sum + {{(SW-DW){prod[k][DW-1]}}, prod[k]};
        end
        if ((&sum[SW-1:DW-1]) || !(|sum[SW-1:DW-1])) begin
            dout_nxt = sum[DW-1:0];
            sov_nxt  = 1'b0;
        end else begin
            dout_nxt = sum[SW-1] ? NEG_MIN : POS_MAX;
            sov_nxt  = 1'b1;
        end
    end

    // Pipeline registers: tap line, product stage and output stage, all gated by i_en.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int unsigned k = 0; k < FIR_DEPTH; k++) begin
                tap[k]  <= '0;
                prod[k] <= '0;
            end
            pov             <= '0;
            ov_dout         <= '0;
            o_prod_overflow <= 1'b0;
            o_sum_overflow  <= 1'b0;
        end else if (i_en) begin
            tap[0] <= iv_din;
            for (int unsigned k = 1; k < FIR_DEPTH; k++) begin
                tap[k] <= tap[k-1];
            end
            for (int unsigned k = 0; k < FIR_DEPTH; k++) begin
                prod[k] <= prod_nxt[k];
            end
            pov             <= pov_nxt;
            ov_dout         <= dout_nxt;
            o_prod_overflow <= |pov;
            o_sum_overflow  <= sov_nxt;
        end
    end

endmodule

// File: tb/tb_fir_filter_core.sv
// tb_fir_filter_core: scoreboard bench for fir_filter_core with default taps and
// with all-negative-one taps; expected samples come from an arithmetic model.
module tb_fir_filter_core;

    localparam int DW = 24;
    localparam int ND = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          pov;
        logic          sov;
    } exp_t;

    logic          tb_clk = 1'b0;
    logic          i_rst;
    logic          i_en;
    logic [DW-1:0] iv_din;
    logic [DW-1:0] def_dout, sat_dout;
    logic          def_pov, def_sov, sat_pov, sat_sov;

    int total = 0;
    int bad   = 0;

    exp_t q_def[$];
    exp_t q_sat[$];
    longint coef_def[ND];
    longint coef_sat[ND];
    longint hist[ND+2];

    always #5 tb_clk = ~tb_clk;

    fir_filter_core #(.DATA_WIDTH(DW), .FIR_DEPTH(ND)) dut_def (
        .i_clk(tb_clk), .i_rst(i_rst), .i_en(i_en), .iv_din(iv_din),
        .ov_dout(def_dout), .o_prod_overflow(def_pov), .o_sum_overflow(def_sov)
    );

    fir_filter_core #(.DATA_WIDTH(DW), .FIR_DEPTH(ND),
                      .COEFFS({ND{24'h800000}})) dut_sat (
        .i_clk(tb_clk), .i_rst(i_rst), .i_en(i_en), .iv_din(iv_din),
        .ov_dout(sat_dout), .o_prod_overflow(sat_pov), .o_sum_overflow(sat_sov)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", nm, act, expv, $time);
        end
    endtask

    // Output sample M is the sum over k of clamp(floor(x[M-2-k]*c[k] / 2^23)), then clamped.
    function automatic exp_t model(input longint c[ND]);
        exp_t   r;
        longint s;
        longint p;
        s     = 0;
        r.pov = 1'b0;
        for (int k = 0; k < ND; k++) begin
            p = (hist[k+2] * c[k]) >>> (DW - 1);
            if (p > 64'sd8388607) begin
                p = 64'sd8388607;
                r.pov = 1'b1;
            end else if (p < -64'sd8388608) begin
                p = -64'sd8388608;
                r.pov = 1'b1;
            end
            s += p;
        end
        r.sov = 1'b1;
        if (s > 64'sd8388607) s = 64'sd8388607;
        else if (s < -64'sd8388608) s = -64'sd8388608;
        else r.sov = 1'b0;
        r.d = DW'(s);
        return r;
    endfunction

    task automatic issue(input logic en, input logic [DW-1:0] x);
        @(negedge tb_clk);
        i_en   = en;
        iv_din = x;
        if (en) begin
            for (int k = ND + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'($signed(x));
            q_def.push_back(model(coef_def));
            q_sat.push_back(model(coef_sat));
        end
    endtask

    // Monitor: pops an expected sample for every enabled edge, otherwise expects held outputs.
    exp_t last_def = '{'0, 1'b0, 1'b0};
    exp_t last_sat = '{'0, 1'b0, 1'b0};
    always begin
        logic en_s, rst_s;
        exp_t e;
        @(posedge tb_clk);
        en_s  = i_en;
        rst_s = i_rst;
        #1;
        if (!rst_s) begin
            last_def = '{'0, 1'b0, 1'b0};
            last_sat = '{'0, 1'b0, 1'b0};
        end else if (en_s) begin
            if (q_def.size() == 0 || q_sat.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow def=%0d sat=%0d", q_def.size(), q_sat.size());
            end else begin
                last_def = q_def.pop_front();
                last_sat = q_sat.pop_front();
            end
        end
        e = last_def;
        chk("def_dout", def_dout, e.d);
        chk("def_pov", DW'(def_pov), DW'(e.pov));
        chk("def_sov", DW'(def_sov), DW'(e.sov));
        e = last_sat;
        chk("sat_dout", sat_dout, e.d);
        chk("sat_pov", DW'(sat_pov), DW'(e.pov));
        chk("sat_sov", DW'(sat_sov), DW'(e.sov));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        for (int k = 0; k < ND; k++) begin
            coef_def[k] = 64'sd1048576;
            coef_sat[k] = -64'sd8388608;
        end
        for (int k = 0; k < ND + 2; k++) hist[k] = 0;
        i_rst  = 1'b0;
        i_en   = 1'b0;
        iv_din = '0;
        repeat (3) @(negedge tb_clk);
        i_rst = 1'b1;

        // Impulse: eight samples of 0x0FFFFF after two enabled edges, then zero.
        issue(1'b1, 24'h7FFFFF);
        repeat (14) issue(1'b1, 24'h000000);

        // Step with a five-cycle enable gap in the middle of the ramp.
        repeat (5) issue(1'b1, 24'h400000);
        repeat (5) issue(1'b0, DW'($urandom));
        repeat (10) issue(1'b1, 24'h400000);

        // Most negative input: default taps stay in range, -1 taps saturate.
        repeat (12) issue(1'b1, 24'h800000);
        repeat (4) issue(1'b1, 24'h7FFFFF);

        // Random samples with random enable, extremes mixed in.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0:       v = 32'h0080_0000;
                1:       v = 32'h007F_FFFF;
                default: v = int'($urandom);
            endcase
            issue(($urandom_range(0, 4) != 0), DW'(v));
        end

        // Asynchronous reset mid-stream with history in the taps.
        repeat (3) issue(1'b1, 24'h3ABCDE);
        @(negedge tb_clk);
        i_en = 1'b0;
        #2;
        i_rst = 1'b0;
        #1;
        chk("rst_def_dout", def_dout, '0);
        chk("rst_def_pov", DW'(def_pov), '0);
        chk("rst_def_sov", DW'(def_sov), '0);
        chk("rst_sat_dout", sat_dout, '0);
        chk("rst_sat_pov", DW'(sat_pov), '0);
        chk("rst_sat_sov", DW'(sat_sov), '0);
        for (int k = 0; k < ND + 2; k++) hist[k] = 0;
        repeat (3) @(negedge tb_clk);
        i_rst = 1'b1;
        repeat (4) issue(1'b1, 24'h123456);

        // Two periods of a full-scale 100 Hz sine at 44 kHz.
        for (int n = 0; n < 880; n++) begin
            v = $rtoi($floor(8388607.0 * $sin(2.0 * 3.14159265358979 * n / 440.0) + 0.5));
            issue(1'b1, DW'(v));
        end

        repeat (4) issue(1'b0, '0);
        total++;
        if (q_def.size() != 0 || q_sat.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover act=%0d/%0d exp=0/0", q_def.size(), q_sat.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
